// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC register, single-outstanding imem handshake and IF/ID register.
// Responses to a request that was overtaken by a redirect are drained in DROP and never reach IF/ID.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic [31:0] i_next_pc,
  output logic [31:0] o_IF_pc,
  output logic [31:0] o_IF_inst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_imem_valid,
  output logic [31:0] o_ID_pc,
  output logic [31:0] o_ID_pc_four,
  output logic [31:0] o_ID_inst,
  output logic        o_ID_valid
);

  typedef enum logic [1:0] {BOOT, REQ, HOLD, DROP} state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] addr_q;
  logic [31:0] inst_buf;
  logic [31:0] id_pc_q;
  logic [31:0] id_pc_four_q;
  logic [31:0] id_inst_q;
  logic        id_valid_q;
  logic        if_valid;
  logic [31:0] pc_load;

  assign pc_load  = {i_next_pc[31:2], 2'b00};
  assign if_valid = ((state == REQ) && i_imem_valid) || (state == HOLD);

  assign o_IF_pc = pc_q;

  always_comb begin
    o_IF_inst = NOP_INST;
    if (state == HOLD)
      o_IF_inst = inst_buf;
    else if ((state == REQ) && i_imem_valid)
      o_IF_inst = i_imem_rdata;
  end

  // The address of an outstanding request must not move, so DROP replays the latched one.
  assign o_imem_req  = (state == REQ) || (state == DROP);
  assign o_imem_addr = (state == REQ) ? pc_q : addr_q;

  assign o_ID_pc      = id_pc_q;
  assign o_ID_pc_four = id_pc_four_q;
  assign o_ID_inst    = id_inst_q;
  assign o_ID_valid   = id_valid_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= BOOT;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      inst_buf     <= '0;
      id_pc_q      <= '0;
      id_pc_four_q <= 32'd4;
      id_inst_q    <= NOP_INST;
      id_valid_q   <= 1'b0;
    end else begin
      if (state == REQ)
        addr_q <= pc_q;

      if (i_flush) begin
        pc_q         <= pc_load;
        inst_buf     <= '0;
        id_pc_q      <= '0;
        id_pc_four_q <= 32'd4;
        id_inst_q    <= NOP_INST;
        id_valid_q   <= 1'b0;
        state <= (((state == REQ) || (state == DROP)) && !i_imem_valid) ? DROP : REQ;
      end else if (i_stall) begin
        // A response arriving under stall is parked so the request slot can close.
        case (state)
          BOOT: state <= REQ;
          REQ: begin
            if (i_imem_valid) begin
              inst_buf <= i_imem_rdata;
              state    <= HOLD;
            end
          end
          HOLD: state <= HOLD;
          DROP: begin
            if (i_imem_valid)
              state <= REQ;
          end
          default: state <= BOOT;
        endcase
      end else if (if_valid) begin
        pc_q         <= pc_load;
        id_pc_q      <= pc_q;
        id_pc_four_q <= pc_q + 32'd4;
        id_inst_q    <= o_IF_inst;
        id_valid_q   <= 1'b1;
        state        <= REQ;
      end else begin
        id_pc_q      <= '0;
        id_pc_four_q <= 32'd4;
        id_inst_q    <= NOP_INST;
        id_valid_q   <= 1'b0;
        if ((state != DROP) || i_imem_valid)
          state <= REQ;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a variable-latency memory model and an IF/ID scoreboard.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        use_override = 1'b0;
  logic [31:0] override_pc = '0;
  logic [31:0] next_pc;
  logic [31:0] if_pc, if_inst, imem_addr, imem_rdata;
  logic [31:0] id_pc, id_pc_four, id_inst;
  logic        imem_req, imem_valid, id_valid;

  int latency = 0;
  int wait_cnt = 0;
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;
  exp_t sb[$];

  logic        mon_en = 1'b0;
  logic        prev_stall = 1'b0;
  logic        prev_flush = 1'b0;
  logic [31:0] last_pc = '0, last_inst = '0;
  logic        last_valid = 1'b0;

  fetch_stage dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_stall      (stall),
    .i_flush      (flush),
    .i_next_pc    (next_pc),
    .o_IF_pc      (if_pc),
    .o_IF_inst    (if_inst),
    .o_imem_req   (imem_req),
    .o_imem_addr  (imem_addr),
    .i_imem_rdata (imem_rdata),
    .i_imem_valid (imem_valid),
    .o_ID_pc      (id_pc),
    .o_ID_pc_four (id_pc_four),
    .o_ID_inst    (id_inst),
    .o_ID_valid   (id_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0008)
      return 32'h0000_0063;
    return 32'h00A0_0093 + {a[21:0], 10'b0};
  endfunction

  // Memory answers after `latency` waiting cycles; predictor model is sequential fetch unless overridden.
  assign imem_valid = imem_req && (wait_cnt >= latency);
  assign imem_rdata = imem_valid ? mem_word(imem_addr) : 32'hDEAD_BEEF;
  assign next_pc    = use_override ? override_pc : if_pc + 32'd4;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wait_cnt <= 0;
    else if (imem_req && !imem_valid)
      wait_cnt <= wait_cnt + 1;
    else
      wait_cnt <= 0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic s, input logic f, input logic ov, input logic [31:0] pc);
    stall        = s;
    flush        = f;
    use_override = ov;
    override_pc  = pc;
  endtask

  task automatic pushExp(input logic [31:0] pc);
    sb.push_back('{pc: pc, inst: mem_word(pc)});
  endtask

  task automatic waitIfPc(input logic [31:0] target);
    int n = 0;
    while (if_pc !== target && n < 50) begin
      tick();
      n++;
    end
    checkOutput("wait_if_pc", if_pc, target);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_req"}, {31'd0, imem_req}, 32'd0);
    checkOutput({tag, "_addr"}, imem_addr, 32'd0);
    checkOutput({tag, "_if_pc"}, if_pc, 32'd0);
    checkOutput({tag, "_if_inst"}, if_inst, NOP);
    checkOutput({tag, "_id_pc"}, id_pc, 32'd0);
    checkOutput({tag, "_id_four"}, id_pc_four, 32'd4);
    checkOutput({tag, "_id_inst"}, id_inst, NOP);
    checkOutput({tag, "_id_valid"}, {31'd0, id_valid}, 32'd0);
  endtask

  always @(posedge clk) begin
    prev_stall <= stall;
    prev_flush <= flush;
  end

  // Every non-stalled, non-flushed edge that leaves IF/ID valid must deliver the next expected instruction.
  always @(negedge clk) begin
    if (mon_en && !prev_flush) begin
      if (prev_stall) begin
        checkOutput("stall_hold_pc", id_pc, last_pc);
        checkOutput("stall_hold_inst", id_inst, last_inst);
        checkOutput("stall_hold_valid", {31'd0, id_valid}, {31'd0, last_valid});
      end else if (id_valid) begin
        checks++;
        assert (sb.size() != 0)
        else begin
          errors++;
          $error("[TB] FAIL sb_unexpected: observed ID pc %h, expected no instruction", id_pc);
        end
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("sb_id_pc", id_pc, e.pc);
          checkOutput("sb_id_pc_four", id_pc_four, e.pc + 32'd4);
          checkOutput("sb_id_inst", id_inst, e.inst);
        end
      end
    end
    last_pc    <= id_pc;
    last_inst  <= id_inst;
    last_valid <= id_valid;
  end

  initial begin
    // Reset values and the single BOOT cycle
    tick();
    tick();
    checkResetOutputs("reset");
    pushExp(32'h0);
    pushExp(32'h4);
    pushExp(32'h8);
    pushExp(32'hC);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    checkOutput("boot_req", {31'd0, imem_req}, 32'd0);
    tick();
    checkOutput("first_req", {31'd0, imem_req}, 32'd1);
    checkOutput("first_addr", imem_addr, 32'h0);
    checkOutput("first_if_inst", if_inst, 32'h00A0_0093);

    // Stall for three cycles while the response for PC 8 arrives
    waitIfPc(32'h8);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("hold_req", {31'd0, imem_req}, 32'd0);
      checkOutput("hold_if_inst", if_inst, 32'h0000_0063);
      checkOutput("hold_id_pc", id_pc, 32'h4);
      checkOutput("hold_id_valid", {31'd0, id_valid}, 32'd1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("release_id_pc", id_pc, 32'h8);
    checkOutput("release_id_inst", id_inst, 32'h0000_0063);

    // Flush while the response is valid
    waitIfPc(32'h10);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h100);
    tick();
    checkOutput("flush_addr", imem_addr, 32'h100);
    checkOutput("flush_req", {31'd0, imem_req}, 32'd1);
    checkOutput("flush_id_valid", {31'd0, id_valid}, 32'd0);
    checkOutput("flush_id_inst", id_inst, NOP);
    checkOutput("sb_empty_1", sb.size(), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    pushExp(32'h100);
    pushExp(32'h104);

    // Redirect to 0x40, then flush to 0x200 while 0x40 is still outstanding
    waitIfPc(32'h108);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h40);
    tick();
    checkOutput("sb_empty_2", sb.size(), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h40);
    latency = 3;
    tick();
    checkOutput("slow_addr", imem_addr, 32'h40);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h200);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      checkOutput("drop_req", {31'd0, imem_req}, 32'd1);
      checkOutput("drop_addr", imem_addr, 32'h40);
      if (imem_valid)
        break;
      tick();
    end
    tick();
    checkOutput("after_drop_addr", imem_addr, 32'h200);
    checkOutput("after_drop_id_valid", {31'd0, id_valid}, 32'd0);
    pushExp(32'h200);
    pushExp(32'h204);

    // Flush and stall together: flush wins, low PC bits are cleared
    waitIfPc(32'h208);
    latency = 0;
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h303);
    tick();
    checkOutput("fs_if_pc", if_pc, 32'h300);
    checkOutput("fs_id_valid", {31'd0, id_valid}, 32'd0);
    checkOutput("fs_id_inst", id_inst, NOP);
    checkOutput("fs_id_pc", id_pc, 32'h0);
    checkOutput("fs_id_four", id_pc_four, 32'h4);
    checkOutput("sb_empty_3", sb.size(), 32'd0);

    // PC wrap at the top of the address space
    applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    tick();
    checkOutput("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    pushExp(32'hFFFF_FFFC);
    pushExp(32'h0);
    tick();
    checkOutput("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
    checkOutput("wrap_id_four", id_pc_four, 32'h0);
    checkOutput("wrap_next_addr", imem_addr, 32'h0);
    tick();
    latency = 3;
    tick();
    tick();
    checkOutput("wait_req", {31'd0, imem_req}, 32'd1);
    checkOutput("wait_id_valid", {31'd0, id_valid}, 32'd0);
    checkOutput("sb_empty_4", sb.size(), 32'd0);

    // Asynchronous reset in the middle of a memory wait
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    checkResetOutputs("midreset");
    tick();
    latency = 0;
    rst_n   = 1'b1;
    checkOutput("reboot_req", {31'd0, imem_req}, 32'd0);
    tick();
    checkOutput("reboot_first_req", {31'd0, imem_req}, 32'd1);
    checkOutput("reboot_first_addr", imem_addr, 32'h0);
    checkOutput("reboot_if_inst", if_inst, 32'h00A0_0093);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the RV32I 5-stage pipeline: owns the PC register, the instruction-memory request handshake and the IF/ID pipeline register. Drives the branch predictor with the current IF PC and instruction, and consumes its next-PC and flush outputs. The hazard unit supplies a stall. Supports a variable-latency instruction memory without losing or duplicating instructions across stalls and redirects.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INST, 32'h0000_0013, bubble encoding (addi x0,x0,0)
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_stall  in  1  hazard-unit stall; holds PC and IF/ID
- i_flush  in  1  predictor mispredict; redirect to i_next_pc, squash IF/ID
- i_next_pc  in  32  predictor next PC; corrected PC when i_flush=1
- o_IF_pc  out  32  current fetch PC, to predictor
- o_IF_inst  out  32  current IF instruction, to predictor; NOP_INST when none valid
- o_imem_req  out  1  instruction-memory request
- o_imem_addr  out  32  request address, word aligned
- i_imem_rdata  in  32  read data, meaningful only with i_imem_valid
- i_imem_valid  in  1  response for the outstanding request
- o_ID_pc  out  32  IF/ID PC
- o_ID_pc_four  out  32  IF/ID PC+4
- o_ID_inst  out  32  IF/ID instruction
- o_ID_valid  out  1  IF/ID holds a real instruction

## Operation
- Registers: pc_q, addr_q (outstanding request address), inst_buf, state, IF/ID {pc, pc_four, inst, valid}.
- Memory protocol: while o_imem_req=1, o_imem_addr stays stable until i_imem_valid. Exactly one request is outstanding. The response arrives in the same or a later cycle.
- States:
  - BOOT: reset state. req=0. Go to REQ next cycle.
  - REQ: req=1, addr=pc_q (addr_q<=pc_q). If i_imem_valid, IF is valid and o_IF_inst=i_imem_rdata; otherwise o_IF_inst=NOP_INST. o_IF_pc=pc_q.
  - HOLD: req=0. Instruction is held in inst_buf. o_IF_inst=inst_buf, IF valid.
  - DROP: req=1, addr=addr_q (stale request after a flush). The response is discarded. o_IF_inst=NOP_INST.
- Priority each cycle: i_flush > i_stall > advance.
- i_flush:
  - pc_q<=i_next_pc.
  - IF/ID<={0,4,NOP_INST,0}.
  - inst_buf is discarded.
  - Next state:
    - DROP if in REQ without i_imem_valid.
    - Stay in DROP if already in DROP and i_imem_valid=0.
    - Otherwise REQ.
- i_stall (no flush):
  - pc_q, IF/ID and addr_q hold.
  - REQ with valid: inst_buf<=i_imem_rdata, go to HOLD.
  - REQ without valid: remain in REQ.
  - HOLD: remain in HOLD.
- Advance (no stall, no flush):
  - REQ with valid, or HOLD: pc_q<=i_next_pc; IF/ID<={pc_q, pc_q+4, inst, 1}; state REQ.
  - REQ without valid: IF/ID<=bubble, pc_q holds.
  - DROP with valid: go to REQ, IF/ID<=bubble.
  - DROP without valid: IF/ID<=bubble.
- pc_four is a 32-bit add that wraps mod 2^32 (32'hFFFF_FFFC -> 0). i_next_pc[1:0] is forced to 0 on load.

## Timing
- Reset values: pc_q=RESET_PC, state=BOOT, o_imem_req=0, o_imem_addr=RESET_PC, o_IF_inst=NOP_INST, o_ID_pc=0, o_ID_pc_four=4, o_ID_inst=NOP_INST, o_ID_valid=0, inst_buf=0.
- First request is asserted in the 2nd rising edge's cycle after reset deassertion (one BOOT cycle).
- With zero-wait memory, throughput is 1 instruction/cycle. An instruction seen in IF in cycle n appears on o_ID_* in cycle n+1.
- A redirect costs the IF/ID slot plus any memory latency. A flush with an outstanding request adds at least one DROP cycle.
- o_IF_pc and o_IF_inst are combinational from state, pc_q, inst_buf and i_imem_rdata. All o_ID_* and o_imem_* outputs are registered or state-decoded, with no path from i_stall or i_flush.
- An asynchronous reset mid-transaction returns to BOOT. Any in-flight response in the first cycle after reset is ignored, because BOOT does not sample i_imem_valid.

## Test plan
- Zero-wait memory returning inst = 32'h00A00093 at every address, no stall/flush, i_next_pc=o_IF_pc+4 -> o_ID_pc = 0,4,8,12 on consecutive cycles from cycle 3, o_ID_valid=1, o_ID_pc_four=o_ID_pc+4.
- i_stall=1 for 3 cycles while REQ receives inst 32'h00000063 at PC 8 -> state HOLD, o_imem_req=0, o_IF_inst=32'h00000063 throughout, o_ID_* unchanged; on release o_ID_pc=8, o_ID_inst=32'h00000063, and no duplicate or lost instruction.
- i_flush=1 with i_next_pc=32'h100 while a response is valid -> next cycle o_imem_addr=32'h100, o_ID_valid=0, o_ID_inst=NOP_INST.
- Memory with 3-cycle latency, flush to 32'h200 one cycle after a request to 32'h40 -> o_imem_addr stays 32'h40 until valid, that response is never written to IF/ID, and the next request is 32'h200.
- i_flush and i_stall together -> flush wins: pc_q=i_next_pc, IF/ID is bubbled.
- PC 32'hFFFF_FFFC advancing -> o_ID_pc_four=0, next fetch address 0. Asserting reset mid-wait -> all outputs take their reset values within the same cycle.
